// File: rtl/alu.sv
// Registered 32-bit RV32I integer ALU: one result per cycle, one-cycle latency.
// A shared adder serves ADD/SUB/SLT/SLTU; a single right shifter serves all shifts.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand_A,
    input  logic [31:0] operand_B,
    input  logic [2:0]  func,
    input  logic        control,
    output logic [31:0] result
);

    localparam logic [2:0] FnAdd  = 3'b000;
    localparam logic [2:0] FnSll  = 3'b001;
    localparam logic [2:0] FnSlt  = 3'b010;
    localparam logic [2:0] FnSltu = 3'b011;
    localparam logic [2:0] FnXor  = 3'b100;
    localparam logic [2:0] FnSr   = 3'b101;
    localparam logic [2:0] FnOr   = 3'b110;
    localparam logic [2:0] FnAnd  = 3'b111;

    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Log-depth right shifter; fill selects zero or sign extension.
    function automatic logic [31:0] shift_right(input logic [31:0] v, input logic [4:0] amt,
                                                input logic fill);
        logic [31:0] r;
        logic [31:0] mask;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (amt[i]) begin
                mask = ~(32'hFFFF_FFFF >> (1 << i));
                r    = (r >> (1 << i)) | (fill ? mask : 32'h0);
            end
        end
        return r;
    endfunction

    logic        sub_sel;
    logic [31:0] b_opnd;
    logic [32:0] sum;
    logic        lt_signed;
    logic        lt_unsigned;

    logic        shift_left;
    logic        shift_fill;
    logic [31:0] shift_in;
    logic [31:0] shift_out;

    logic [31:0] result_d;
    logic [31:0] result_q;

    // Compares reuse the subtractor regardless of control.
    always_comb begin
        sub_sel = ((func == FnAdd) && control) || (func == FnSlt) || (func == FnSltu);
        b_opnd  = sub_sel ? ~operand_B : operand_B;
        sum     = {1'b0, operand_A} + {1'b0, b_opnd} + {32'h0, sub_sel};
    end

    // Carry out of A + ~B + 1 is set exactly when A >= B unsigned.
    always_comb begin
        lt_unsigned = ~sum[32];
        if (operand_A[31] != operand_B[31]) begin
            lt_signed = operand_A[31];
        end else begin
            lt_signed = sum[31];
        end
    end

    // Left shifts go through the right shifter on bit-reversed data.
    always_comb begin
        shift_left = (func == FnSll);
        shift_fill = (func == FnSr) && control && operand_A[31];
        shift_in   = shift_left ? bit_reverse(operand_A) : operand_A;
        shift_out  = shift_right(shift_in, operand_B[4:0], shift_fill);
    end

    always_comb begin
        result_d = '0;
        case (func)
            FnAdd:   result_d = sum[31:0];
            FnSll:   result_d = bit_reverse(shift_out);
            FnSlt:   result_d = {31'h0, lt_signed};
            FnSltu:  result_d = {31'h0, lt_unsigned};
            FnXor:   result_d = operand_A ^ operand_B;
            FnSr:    result_d = shift_out;
            FnOr:    result_d = operand_A | operand_B;
            FnAnd:   result_d = operand_A & operand_B;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues expected results, a monitor checks each edge.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [2:0]  func;
    logic        control;
    logic [31:0] result;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .func      (func),
        .control   (control),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic c);
        logic signed [31:0] sa;
        int unsigned        sh;
        sa = a;
        sh = b[4:0];
        case (f)
            3'd0:    return c ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return c ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Drive one operation for the coming edge and queue what it must produce.
    task automatic issue(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic c, input logic [31:0] exp,
                         input string tag);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        operand_A = a;
        operand_B = b;
        func      = f;
        control   = c;
        e.exp     = exp;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                               input logic c, input string tag);
        issue(1'b0, a, b, f, c, model(a, b, f, c), tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (result !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.tag, result, e.exp);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        c;
        int          wait_cycles;

        reset     = 1'b1;
        operand_A = 32'h0;
        operand_B = 32'h0;
        func      = 3'd0;
        control   = 1'b0;

        issue(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd0, 1'b0, 32'h0, "reset");
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd6, 1'b0, 32'h0, "reset_hold");
        issue(1'b0, 32'h0000_0001, 32'h0000_0001, 3'd0, 1'b0, 32'h2, "add_first_after_reset");
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 32'h0, "add_wrap");
        issue(1'b0, 32'h0000_0001, 32'h0000_0001, 3'd0, 1'b1, 32'h0, "sub_1_1");
        issue(1'b0, 32'h0000_0000, 32'h0000_0000, 3'd0, 1'b1, 32'h0, "sub_0_0");
        issue(1'b0, 32'h0000_0000, 32'h0000_0001, 3'd0, 1'b1, 32'hFFFF_FFFF, "sub_wrap");
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 32'h1, "slt_neg");
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0, 32'h0, "sltu_big");
        issue(1'b0, 32'h0000_0001, 32'h0000_0001, 3'd2, 1'b0, 32'h0, "slt_equal");
        issue(1'b0, 32'h0000_0001, 32'h0000_0001, 3'd3, 1'b1, 32'h0, "sltu_equal");
        issue(1'b0, 32'h0000_0002, 32'h0000_0001, 3'd1, 1'b0, 32'h4, "sll_2_1");
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd5, 1'b0, 32'h0000_0555, "srl_21");
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd5, 1'b1, 32'hFFFF_FD55, "sra_21");
        issue(1'b0, 32'h8000_00FF, 32'h00FF_0000, 3'd5, 1'b1, 32'h8000_00FF, "sra_hi_bits_ignored");
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd4, 1'b0, 32'hFFFF_FFFF, "xor");
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd6, 1'b1, 32'hFFFF_FFFF, "or");
        issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd7, 1'b1, 32'h0000_0000, "and");
        issue(1'b0, 32'h8000_0000, 32'h0000_001F, 3'd1, 1'b1, 32'h0000_0000, "sll_31_out");
        issue(1'b0, 32'h8000_0000, 32'h0000_001F, 3'd5, 1'b1, 32'hFFFF_FFFF, "sra_31");
        issue(1'b1, 32'h1111_1111, 32'h2222_2222, 3'd4, 1'b0, 32'h0, "reset_mid_stream");
        issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 3'd2, 1'b0, 32'h0, "slt_pos_vs_min");

        // Back-to-back sweep through all ten operations.
        for (int i = 0; i < 10; i++) begin
            f = (i < 8) ? 3'(i) : ((i == 8) ? 3'd0 : 3'd5);
            c = (i >= 8);
            issue_model($urandom, $urandom, f, c, "sweep");
        end

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = (a[0]) ? 32'hFFFF_FFFF : b;
            f = 3'($urandom_range(0, 7));
            c = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                issue(1'b1, a, b, f, c, 32'h0, "rand_reset");
            end else begin
                issue_model(a, b, f, c, "rand");
            end
        end

        @(negedge clk);
        reset = 1'b0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
